// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit and its prefetch buffer:
//   - default parameter values (address width, instruction width, buffer depth)
//   - position of the opcode field inside an instruction word
//   - the fetch FSM state encoding
//   - a pointer-width helper that stays legal for a single-entry buffer
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 2;

    // Opcode occupies the top six bits of the instruction word.
    localparam int OPC_MSB = DEF_DATA_W - 1;
    localparam int OPC_LSB = DEF_DATA_W - 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    // A one-entry buffer still needs a one-bit pointer to keep vectors legal.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small prefetch buffer holding {instruction, pc} entries between instruction
// memory and the control unit. Head is presented combinationally so an entry
// is visible the cycle after it is pushed.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-low reset (buffer empty)
//   flush      in   discard every entry; wins over push and pop
//   push       in   write push_data at the tail
//   push_data  in   WIDTH-bit entry
//   pop        in   remove the head entry (ignored when empty)
//   head_data  out  current head entry (undefined when empty)
//   empty      out  no entries held
//   full       out  DEPTH entries held
//
// Push and pop in the same cycle are safe, including when the buffer is full
// (the pop frees the slot the push lands in).
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_DATA_W + DEF_ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             pop_ok;
    logic             push_ok;

    // Pointers wrap explicitly so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && !flush && (!full || pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (pop_ok) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; the empty flag qualifies every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetches sequential instruction words from instruction memory into a small
// prefetch buffer and offers the buffer head to the control unit. A taken
// branch (pc_src) flushes the buffer and restarts fetching at branch_target.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous, active-low reset
//   imem_req       out  read request to instruction memory
//   imem_addr      out  ADDR_W word address of the request
//   imem_gnt       in   memory accepts the request this cycle
//   imem_rvalid    in   read data valid (one per grant, in order)
//   imem_rdata     in   DATA_W read data
//   issue_valid    out  buffer head holds an instruction
//   issue_ready    in   control unit consumes the head
//   instr          out  DATA_W head instruction (0 when empty)
//   opcode         out  6-bit opcode field of the head (0 when empty)
//   instr_pc       out  ADDR_W address of the head (0 when empty)
//   pc_src         in   branch taken: flush and redirect
//   branch_target  in   ADDR_W redirect address, sampled when pc_src=1
//
// Only one memory request is ever outstanding: REQ issues it, WAIT collects the
// response, DRAIN swallows a response whose request a redirect made stale.
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [DATA_W-1:0] instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              pc_src,
    input  logic [ADDR_W-1:0] branch_target
);

    localparam int OPC_BITS = OPC_MSB - OPC_LSB + 1;
    localparam int ENTRY_W  = DATA_W + ADDR_W;

    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] fetch_pc_reg;
    logic [ADDR_W-1:0] inflight_pc_reg;   // address of the granted request

    logic               buf_empty;
    logic               buf_full;
    logic               buf_push;
    logic               buf_pop;
    logic               can_req;
    logic               grant;
    logic [ENTRY_W-1:0] head_entry;
    logic [DATA_W-1:0]  head_instr;
    logic [ADDR_W-1:0]  head_pc;

    // ------------------------------------------------------------------------
    // Request / buffer control
    // ------------------------------------------------------------------------
    assign buf_pop = !buf_empty && issue_ready;

    // A pop this cycle frees a slot, so a full buffer may still request in the
    // pop cycle. That is why imem_req is decoded from state rather than kept in
    // a flop. Once raised it cannot fall before the grant: REQ never pushes, so
    // the buffer only drains while waiting for imem_gnt.
    assign can_req  = !buf_full || buf_pop;
    assign imem_req = (state_reg == ST_REQ) && can_req;
    assign grant    = imem_req && imem_gnt;

    // A response coinciding with a redirect belongs to the old stream.
    assign buf_push = (state_reg == ST_WAIT) && imem_rvalid && !pc_src;

    assign imem_addr = fetch_pc_reg;

    // ------------------------------------------------------------------------
    // Fetch FSM and program counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            fetch_pc_reg    <= '0;
            inflight_pc_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_REQ;
                end
                ST_REQ: begin
                    // A redirect without a grant simply retargets the request.
                    if (grant) begin
                        inflight_pc_reg <= fetch_pc_reg;
                        state_reg       <= pc_src ? ST_DRAIN : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The response is either pushed or, under a redirect,
                    // discarded; in both cases the request is complete.
                    if (imem_rvalid) begin
                        state_reg <= ST_REQ;
                    end else if (pc_src) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid) begin
                        state_reg <= ST_REQ;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            // Redirect wins over the post-grant increment; the increment wraps
            // naturally at the address width.
            if (pc_src) begin
                fetch_pc_reg <= branch_target;
            end else if (grant) begin
                fetch_pc_reg <= fetch_pc_reg + ADDR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Prefetch buffer
    // ------------------------------------------------------------------------
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (pc_src),
        .push      (buf_push),
        .push_data ({imem_rdata, inflight_pc_reg}),
        .pop       (buf_pop),
        .head_data (head_entry),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    assign {head_instr, head_pc} = head_entry;

    // Outputs read zero while the buffer is empty, so unwritten storage never
    // reaches the control unit.
    assign issue_valid = !buf_empty;
    assign instr       = buf_empty ? '0 : head_instr;
    assign instr_pc    = buf_empty ? '0 : head_pc;
    assign opcode      = buf_empty ? '0 : head_instr[DATA_W-1 -: OPC_BITS];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt = 1'b0;
    logic          imem_rvalid = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic          issue_valid;
    logic          issue_ready = 1'b0;
    logic [DW-1:0] instr;
    logic [5:0]    opcode;
    logic [AW-1:0] instr_pc;
    logic          pc_src = 1'b0;
    logic [AW-1:0] branch_target = '0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .instr         (instr),
        .opcode        (opcode),
        .instr_pc      (instr_pc),
        .pc_src        (pc_src),
        .branch_target (branch_target)
    );

    int checks = 0;
    int errors = 0;

    // Environment knobs
    int gnt_prob   = 100;
    int ready_prob = 100;
    int dly_min    = 0;
    int dly_max    = 0;

    // Memory model: at most one pending response
    bit            pending;
    logic [AW-1:0] pend_addr;
    int            pend_dly;

    // Reference model: next address to be fetched, next pc to be issued
    logic [AW-1:0] exp_fetch;
    logic [AW-1:0] exp_issue;
    bit            hold_prev;
    logic [AW-1:0] hold_addr;
    bit            redirect_prev;

    // Observations
    int            cyc;
    int            n_grants;
    int            n_issued;
    int            first_valid_cyc;
    logic [AW-1:0] last_grant_addr;
    logic [AW-1:0] grant_log[$];
    logic          s_req;
    logic          s_valid;
    logic [AW-1:0] s_addr;
    bit            s_grant;
    bit            s_issue;
    logic [AW-1:0] s_issue_pc;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (DW'(a) * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    // One clock cycle: drive at negedge, sample 1ns later, score, advance.
    task automatic cycle(input bit redirect, input logic [AW-1:0] tgt, input bit stray);
        logic [DW-1:0] want;
        cyc++;
        imem_gnt      = (int'($urandom_range(99)) < gnt_prob);
        issue_ready   = (int'($urandom_range(99)) < ready_prob);
        pc_src        = redirect;
        branch_target = tgt;
        if (stray) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end else if (pending && pend_dly == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = issue_valid;
        s_grant = (imem_req === 1'b1) && imem_gnt;
        s_issue = (issue_valid === 1'b1) && issue_ready;

        if (hold_prev) begin
            checks++;
            if (s_req !== 1'b1 || s_addr !== hold_addr) begin
                errors++;
                $display("FAIL req_stable cyc %0d: req=%b addr=%h, required req=1 addr=%h",
                         cyc, s_req, s_addr, hold_addr);
            end
        end
        if (redirect_prev) begin
            checks++;
            if (s_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_empty cyc %0d: issue_valid=%b, required 0", cyc, s_valid);
            end
        end
        if (s_grant) begin
            checks++;
            if (pending) begin
                errors++;
                $display("FAIL one_outstanding cyc %0d: grant with pending=1, required pending=0", cyc);
            end
            checks++;
            if (s_addr !== exp_fetch) begin
                errors++;
                $display("FAIL fetch_addr cyc %0d: addr=%h, required %h", cyc, s_addr, exp_fetch);
            end
            n_grants++;
            last_grant_addr = s_addr;
            grant_log.push_back(s_addr);
        end
        if (s_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (s_issue) begin
            want = mem_word(exp_issue);
            checks++;
            if (instr_pc !== exp_issue || instr !== want || opcode !== want[31:26]) begin
                errors++;
                $display("FAIL issue cyc %0d: pc=%h instr=%h opcode=%h, required pc=%h instr=%h opcode=%h",
                         cyc, instr_pc, instr, opcode, exp_issue, want, want[31:26]);
            end
            s_issue_pc = instr_pc;
            n_issued++;
            exp_issue = exp_issue + 16'd1;
        end

        if (redirect) begin
            exp_fetch = tgt;
            exp_issue = tgt;
        end else if (s_grant) begin
            exp_fetch = exp_fetch + 16'd1;
        end
        hold_prev     = (s_req === 1'b1) && !imem_gnt && !redirect;
        hold_addr     = s_addr;
        redirect_prev = redirect;
        if (imem_rvalid && !stray) pending = 1'b0;
        else if (pending) pend_dly--;
        if (s_grant) begin
            pending   = 1'b1;
            pend_addr = s_addr;
            pend_dly  = int'($urandom_range(dly_max, dly_min));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset         = 1'b0;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        issue_ready   = 1'b0;
        pc_src        = 1'b0;
        branch_target = '0;
        pending       = 1'b0;
        hold_prev     = 1'b0;
        redirect_prev = 1'b0;
        exp_fetch     = '0;
        exp_issue     = '0;
        cyc           = 0;
        n_grants      = 0;
        n_issued      = 0;
        first_valid_cyc = -1;
        grant_log.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== '0 || issue_valid !== 1'b0 ||
            instr !== '0 || opcode !== '0 || instr_pc !== '0) begin
            errors++;
            $display("FAIL %s: req=%b addr=%h valid=%b instr=%h opc=%h pc=%h, required all 0",
                     tag, imem_req, imem_addr, issue_valid, instr, opcode, instr_pc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = $urandom;
        issue_ready = 1'b1; pc_src = 1'b1; branch_target = 16'h1234;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs");
        apply_reset();
        gnt_prob = 100; ready_prob = 100; dly_min = 0; dly_max = 0;
        cycle(1'b0, '0, 1'b0);
        checks++;
        if (s_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: req=%b, required 0", s_req);
        end
        cycle(1'b0, '0, 1'b0);
        checks++;
        if (s_req !== 1'b1 || s_addr !== 16'h0000) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h, required req=1 addr=0000", s_req, s_addr);
        end
        $display("test_reset done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_stream();
        apply_reset();
        gnt_prob = 100; ready_prob = 100; dly_min = 0; dly_max = 0;
        repeat (20) cycle(1'b0, '0, 1'b0);
        checks++;
        if (first_valid_cyc != 4) begin
            errors++;
            $display("FAIL first_issue_latency: cycle %0d, required 4", first_valid_cyc);
        end
        checks++;
        if (n_grants != 10 || n_issued != 9) begin
            errors++;
            $display("FAIL stream_count: grants=%0d issued=%0d, required grants=10 issued=9",
                     n_grants, n_issued);
        end
        $display("test_stream done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_backpressure();
        apply_reset();
        gnt_prob = 100; ready_prob = 0; dly_min = 0; dly_max = 0;
        repeat (12) cycle(1'b0, '0, 1'b0);
        checks++;
        if (n_grants != 2 || s_req !== 1'b0 || s_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_stall: grants=%0d req=%b valid=%b, required grants=2 req=0 valid=1",
                     n_grants, s_req, s_valid);
        end
        ready_prob = 100;
        cycle(1'b0, '0, 1'b0);
        checks++;
        if (!s_grant || s_addr !== 16'h0002 || !s_issue) begin
            errors++;
            $display("FAIL pop_cycle_req: grant=%b addr=%h issue=%b, required grant=1 addr=0002 issue=1",
                     s_grant, s_addr, s_issue);
        end
        repeat (6) cycle(1'b0, '0, 1'b0);
        $display("test_backpressure done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        gnt_prob = 100; ready_prob = 100; dly_min = 2; dly_max = 2;
        for (int i = 0; i < 10 && n_grants < 1; i++) cycle(1'b0, '0, 1'b0);
        checks++;
        if (n_grants < 1) begin
            errors++;
            $display("FAIL rw_grant_timeout: grants=%0d, required 1", n_grants);
        end
        cycle(1'b1, 16'h0040, 1'b0);
        checks++;
        if (s_req !== 1'b0) begin
            errors++;
            $display("FAIL rw_wait_no_req: req=%b, required 0", s_req);
        end
        for (int i = 0; i < 20 && n_grants < 2; i++) cycle(1'b0, '0, 1'b0);
        checks++;
        if (n_grants < 2 || last_grant_addr !== 16'h0040) begin
            errors++;
            $display("FAIL rw_target_addr: grants=%0d addr=%h, required grants=2 addr=0040",
                     n_grants, last_grant_addr);
        end
        for (int i = 0; i < 20 && n_issued < 1; i++) cycle(1'b0, '0, 1'b0);
        checks++;
        if (n_issued != 1 || s_issue_pc !== 16'h0040) begin
            errors++;
            $display("FAIL rw_first_issue: issued=%0d pc=%h, required issued=1 pc=0040",
                     n_issued, s_issue_pc);
        end
        $display("test_redirect_wait done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_redirect_issue();
        apply_reset();
        gnt_prob = 100; ready_prob = 0; dly_min = 0; dly_max = 0;
        for (int i = 0; i < 20 && n_grants < 2; i++) cycle(1'b0, '0, 1'b0);
        checks++;
        if (n_grants < 2) begin
            errors++;
            $display("FAIL ri_grant_timeout: grants=%0d, required 2", n_grants);
        end
        ready_prob = 100;
        cycle(1'b1, 16'h0100, 1'b0);
        checks++;
        if (!s_issue || s_issue_pc !== 16'h0000 || n_issued != 1) begin
            errors++;
            $display("FAIL ri_issue_consumed: issue=%b pc=%h issued=%0d, required issue=1 pc=0000 issued=1",
                     s_issue, s_issue_pc, n_issued);
        end
        cycle(1'b0, '0, 1'b0);
        checks++;
        if (s_valid !== 1'b0 || !s_grant || s_addr !== 16'h0100) begin
            errors++;
            $display("FAIL ri_resume: valid=%b grant=%b addr=%h, required valid=0 grant=1 addr=0100",
                     s_valid, s_grant, s_addr);
        end
        for (int i = 0; i < 20 && n_issued < 2; i++) cycle(1'b0, '0, 1'b0);
        checks++;
        if (n_issued != 2 || s_issue_pc !== 16'h0100) begin
            errors++;
            $display("FAIL ri_next_issue: issued=%0d pc=%h, required issued=2 pc=0100",
                     n_issued, s_issue_pc);
        end
        $display("test_redirect_issue done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_wrap();
        int n0;
        apply_reset();
        gnt_prob = 100; ready_prob = 100; dly_min = 0; dly_max = 0;
        cycle(1'b0, '0, 1'b0);
        cycle(1'b1, 16'hFFFE, 1'b0);
        grant_log.delete();
        n0 = n_issued;
        for (int i = 0; i < 40 && (n_issued - n0) < 3; i++) cycle(1'b0, '0, 1'b0);
        checks++;
        if (grant_log.size() < 3) begin
            errors++;
            $display("FAIL wrap_grants: %0d grants, required at least 3", grant_log.size());
        end else if (grant_log[0] !== 16'hFFFE || grant_log[1] !== 16'hFFFF || grant_log[2] !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_grants: %h %h %h, required FFFE FFFF 0000",
                     grant_log[0], grant_log[1], grant_log[2]);
        end
        checks++;
        if ((n_issued - n0) != 3 || s_issue_pc !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_issue: issued=%0d pc=%h, required issued=3 pc=0000",
                     n_issued - n0, s_issue_pc);
        end
        $display("test_wrap done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        gnt_prob = 100; ready_prob = 100; dly_min = 3; dly_max = 3;
        for (int i = 0; i < 10 && n_grants < 1; i++) cycle(1'b0, '0, 1'b0);
        checks++;
        if (n_grants < 1) begin
            errors++;
            $display("FAIL rm_grant_timeout: grants=%0d, required 1", n_grants);
        end
        #2 reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("rm_reset_outputs");
        apply_reset();
        gnt_prob = 0;
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        checks++;
        if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 16'h0000) begin
            errors++;
            $display("FAIL rm_stray_ignored: valid=%b req=%b addr=%h, required valid=0 req=1 addr=0000",
                     s_valid, s_req, s_addr);
        end
        gnt_prob = 100; dly_min = 0; dly_max = 0;
        cycle(1'b0, '0, 1'b0);
        checks++;
        if (s_valid !== 1'b0 || !s_grant || s_addr !== 16'h0000) begin
            errors++;
            $display("FAIL rm_restart: valid=%b grant=%b addr=%h, required valid=0 grant=1 addr=0000",
                     s_valid, s_grant, s_addr);
        end
        for (int i = 0; i < 10 && n_issued < 1; i++) cycle(1'b0, '0, 1'b0);
        checks++;
        if (n_issued != 1 || s_issue_pc !== 16'h0000) begin
            errors++;
            $display("FAIL rm_first_issue: issued=%0d pc=%h, required issued=1 pc=0000",
                     n_issued, s_issue_pc);
        end
        $display("test_reset_mid done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_random();
        bit            redir;
        logic [AW-1:0] tgt;
        apply_reset();
        for (int ph = 0; ph < 4; ph++) begin
            gnt_prob   = 40 + 20 * ph;
            ready_prob = (ph == 1) ? 20 : 70;
            dly_min    = 0;
            dly_max    = 3;
            for (int i = 0; i < 200; i++) begin
                redir = ($urandom_range(99) < 4);
                tgt   = AW'($urandom);
                if ($urandom_range(3) == 0) tgt = 16'hFFFC + AW'($urandom_range(3));
                cycle(redir, tgt, 1'b0);
            end
        end
        checks++;
        if (n_issued < 50) begin
            errors++;
            $display("FAIL random_progress: issued=%0d, required at least 50", n_issued);
        end
        $display("test_random done issued=%0d checks=%0d errors=%0d", n_issued, checks, errors);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_issue();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16: instruction-memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32: instruction width; opcode = instr[DATA_W-1:DATA_W-6].
REQ-003 The block SHALL have parameter DEPTH, default 2: prefetch buffer entries.
REQ-004 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port imem_req  out  1  read request to instruction memory.
REQ-007 The block SHALL have port imem_addr  out  ADDR_W  word address of the request.
REQ-008 The block SHALL have port imem_gnt  in  1  memory accepts the request this cycle.
REQ-009 The block SHALL have port imem_rvalid  in  1  read data valid, one response per granted request, in order.
REQ-010 The block SHALL have port imem_rdata  in  DATA_W  read data.
REQ-011 The block SHALL have port issue_valid  out  1  instruction available to the control unit.
REQ-012 The block SHALL have port issue_ready  in  1  control unit/datapath consumes the instruction.
REQ-013 The block SHALL have port instr  out  DATA_W  head instruction.
REQ-014 The block SHALL have port opcode  out  6  head opcode field, feeding the control unit opcode input.
REQ-015 The block SHALL have port instr_pc  out  ADDR_W  address of the head instruction.
REQ-016 The block SHALL have port pc_src  in  1  branch taken, from control unit.
REQ-017 The block SHALL have port branch_target  in  ADDR_W  redirect address, sampled when pc_src=1.

Function
REQ-018 The block SHALL run FSM states IDLE, REQ, WAIT, DRAIN.
- IDLE→REQ one cycle after reset release.
- REQ: imem_req=1 while buffer free slots > 0; on imem_gnt → WAIT.
- WAIT: on imem_rvalid, push {rdata, addr} and → REQ.
- DRAIN: on imem_rvalid, drop the data and → REQ.
REQ-019 The block SHALL allow at most one outstanding memory request.
REQ-020 The block SHALL increment fetch_pc by 1, modulo 2^ADDR_W, on every grant; wrap from all-ones to 0 without error.
REQ-021 The block SHALL hold imem_addr and imem_req stable until imem_gnt.
REQ-022 The block SHALL assert issue_valid whenever the buffer is non-empty; the head is popped on issue_valid & issue_ready.
REQ-023 The block SHALL drive instr, opcode and instr_pc from the buffer head, giving 2-cycle minimum latency from grant with single-cycle memory.
REQ-024 On pc_src=1 the block SHALL flush the buffer and load fetch_pc=branch_target next cycle.
- Redirect in WAIT → DRAIN.
- Redirect in REQ without grant → drop the request.
- Redirect in REQ with grant in the same cycle → DRAIN.
REQ-025 A redirect in the same cycle as imem_rvalid SHALL discard that response.
REQ-026 A redirect in the same cycle as an issue handshake SHALL count the issue as consumed and then flush the remaining entries.
REQ-027 On buffer full, the block SHALL hold imem_req=0 and the FSM SHALL stay in REQ; no overflow is possible.
REQ-028 With buffer full and issue_ready=1, the block SHALL allow a request in the same cycle as the pop.

Reset
REQ-029 While reset=0, all outputs SHALL be 0, FSM=IDLE, fetch_pc=0, and the buffer empty.
REQ-030 Reset asserted mid-transaction SHALL abandon the outstanding request; any imem_rvalid after release that was not preceded by a grant SHALL be ignored.

Structure
REQ-031 The shared package fetch_pkg SHALL hold the FSM state enum, the OPC_MSB/OPC_LSB constants and the default widths.
REQ-032 The buffer SHALL be sub-module fetch_fifo (parameterised DEPTH, flush input, push/pop same-cycle safe).

Verification
REQ-033 Reset release, imem_gnt=1 always, rvalid 1 cycle later, issue_ready=1 → addresses 0,1,2…; first issue_valid 3 cycles after release, opcode=rdata[31:26].
REQ-034 issue_ready=0 → exactly 2 entries fetched (addr 0,1), then imem_req=0; ready=1 → addr 2 requested in the pop cycle.
REQ-035 pc_src=1, branch_target=0x0040 while WAIT → next rvalid dropped; next imem_addr=0x0040; no stale issue.
REQ-036 pc_src coincident with imem_rvalid and an issue handshake → one issue counted, buffer empty next cycle, fetch resumes at target.
REQ-037 fetch_pc=0xFFFF granted → next imem_addr=0x0000.
REQ-038 reset asserted in WAIT, released, then a stray rvalid → ignored; fetch restarts at 0.
